// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage.
//
// Accepts one EX result at a time. Non-memory ops pass straight to writeback
// one cycle later. Aligned loads/stores hold a data-memory request until
// dmem_ack, then deliver a writeback bundle (with load data lane-selected and
// extended) the following cycle. Misaligned accesses raise misaligned_exc.
// Conflicting read+write or an undefined funct3 becomes a harmless no-op.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   ex_*              : EX-stage result bundle (valid, alu_out, rs2_data,
//                       mem_read, mem_write, funct3, rd, reg_write)
//   stall_out         : high while an access is outstanding (EX must hold)
//   dmem_*            : data-memory request (req, we, addr, wdata, be) and
//                       response (ack, rdata)
//   wb_*              : one-cycle writeback bundle (valid, data, rd, reg_write)
//   misaligned_exc    : one-cycle pulse for a misaligned load/store
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rs2_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misaligned_exc
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state, state_next;

    // Context of the outstanding access, needed when the response arrives.
    logic [2:0] acc_funct3;
    logic [1:0] acc_offset;
    logic       acc_load;
    logic [4:0] acc_rd;

    // Decode of the incoming EX bundle.
    logic        is_mem;
    logic        is_conflict;
    logic        funct3_ok;
    logic        misaligned;
    logic        start_access;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        is_mem      = ex_mem_read | ex_mem_write;
        is_conflict = ex_mem_read & ex_mem_write;

        // BU/HU only exist for loads; stores accept B/H/W.
        funct3_ok = 1'b0;
        case (ex_funct3)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = ex_mem_read;
            default:                funct3_ok = 1'b0;
        endcase

        misaligned = 1'b0;
        case (ex_funct3)
            3'b001, 3'b101: misaligned = ex_alu_out[0];
            3'b010:         misaligned = |ex_alu_out[1:0];
            default:        misaligned = 1'b0;
        endcase

        store_be    = 4'b1111;
        store_wdata = ex_rs2_data;
        case (ex_funct3)
            3'b000: begin
                store_be    = 4'b0001 << ex_alu_out[1:0];
                store_wdata = {4{ex_rs2_data[7:0]}};
            end
            3'b001: begin
                store_be    = 4'b0011 << {ex_alu_out[1], 1'b0};
                store_wdata = {2{ex_rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign start_access = ex_valid && (state == IDLE) && is_mem && !is_conflict
                          && funct3_ok && !misaligned;

    // Masked during reset so EX is never held by a transaction being abandoned.
    assign stall_out = (state == ACCESS) && !reset;

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_access) state_next = ACCESS;
            ACCESS:  if (dmem_ack)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Lane select and extension of the returned read word.
    logic [31:0] shifted_b;
    logic [31:0] shifted_h;
    logic [31:0] load_value;

    always_comb begin
        shifted_b = dmem_rdata >> {acc_offset, 3'b000};
        shifted_h = dmem_rdata >> {acc_offset[1], 4'b0000};
        case (acc_funct3)
            3'b000:  load_value = {{24{shifted_b[7]}}, shifted_b[7:0]};
            3'b001:  load_value = {{16{shifted_h[15]}}, shifted_h[15:0]};
            3'b100:  load_value = {24'h0, shifted_b[7:0]};
            3'b101:  load_value = {16'h0, shifted_h[15:0]};
            default: load_value = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'h0;
            dmem_wdata     <= 32'h0;
            dmem_be        <= 4'h0;
            wb_valid       <= 1'b0;
            wb_data        <= 32'h0;
            wb_rd          <= 5'h0;
            wb_reg_write   <= 1'b0;
            misaligned_exc <= 1'b0;
            acc_funct3     <= 3'h0;
            acc_offset     <= 2'h0;
            acc_load       <= 1'b0;
            acc_rd         <= 5'h0;
        end else begin
            // Writeback and exception are single-cycle pulses.
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            misaligned_exc <= 1'b0;

            if (state == ACCESS) begin
                // Request fields stay untouched until the ack cycle.
                if (dmem_ack) begin
                    dmem_req     <= 1'b0;
                    wb_valid     <= 1'b1;
                    wb_rd        <= acc_rd;
                    wb_data      <= acc_load ? load_value : 32'h0;
                    wb_reg_write <= acc_load && (acc_rd != 5'd0);
                end
            end else if (ex_valid) begin
                wb_rd   <= ex_rd;
                wb_data <= ex_alu_out;
                if (start_access) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= ex_mem_write;
                    dmem_addr  <= {ex_alu_out[31:2], 2'b00};
                    dmem_be    <= ex_mem_write ? store_be : 4'b1111;
                    dmem_wdata <= ex_mem_write ? store_wdata : 32'h0;
                    acc_funct3 <= ex_funct3;
                    acc_offset <= ex_alu_out[1:0];
                    acc_load   <= ex_mem_read;
                    acc_rd     <= ex_rd;
                end else begin
                    // ALU op, misaligned access or no-op: immediate writeback.
                    wb_valid       <= 1'b1;
                    wb_reg_write   <= !is_mem && ex_reg_write && (ex_rd != 5'd0);
                    misaligned_exc <= is_mem && !is_conflict && funct3_ok && misaligned;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Transactions are issued one at a time; expectations come from a
// transaction-level model (access size, byte lanes, extension by arithmetic).
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_rs2_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misaligned_exc;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_alu_out     (ex_alu_out),
        .ex_rs2_data    (ex_rs2_data),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .stall_out      (stall_out),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .misaligned_exc (misaligned_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit f3_legal(input logic [2:0] f3, input bit is_load);
        return (f3 <= 3'd2) || (is_load && (f3 == 3'd4 || f3 == 3'd5));
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic [2:0] f3);
        int n;
        n = acc_bytes(f3);
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] rs2, input logic [2:0] f3);
        logic [31:0] w;
        int n;
        n = acc_bytes(f3);
        w = '0;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = rs2[8*(j % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
        int n;
        logic [31:0] v, mask;
        n = acc_bytes(f3);
        if (n == 4) return word;
        v    = word >> (8 * (addr % 4));
        mask = (32'd1 << (8 * n)) - 32'd1;
        v    = v & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Issue one transaction from IDLE and check it through to writeback.
    // Returns at posedge+1 of the writeback cycle, inputs free for the next op.
    task automatic run_txn(input string nm, input logic [31:0] alu, input logic [31:0] rs2,
                           input logic [4:0] rd, input logic rw, input logic mr,
                           input logic mw, input logic [2:0] f3, input int lat,
                           input logic [31:0] rdata);
        bit is_mem, legal, mis, go;
        logic [3:0]  be_e;
        logic [31:0] wd_e;
        is_mem = mr | mw;
        legal  = is_mem && !(mr && mw) && f3_legal(f3, mr);
        mis    = legal && ((alu % acc_bytes(f3)) != 0);
        go     = legal && !mis;
        be_e   = mw ? exp_be(alu, f3) : 4'b1111;
        wd_e   = mw ? exp_wdata(rs2, f3) : 32'h0;

        ex_valid     = 1'b1;
        ex_alu_out   = alu;
        ex_rs2_data  = rs2;
        ex_rd        = rd;
        ex_reg_write = rw;
        ex_mem_read  = mr;
        ex_mem_write = mw;
        ex_funct3    = f3;
        dmem_ack     = 1'($urandom);   // ack in IDLE must be ignored
        dmem_rdata   = $urandom;
        tick();
        ex_valid   = 1'b0;
        ex_alu_out = $urandom;
        dmem_ack   = 1'b0;

        if (go) begin
            for (int i = 1; i <= lat; i++) begin
                check({nm, " stall"}, 32'(stall_out), 32'd1);
                check({nm, " req"},   32'(dmem_req),  32'd1);
                check({nm, " we"},    32'(dmem_we),   32'(mw));
                check({nm, " addr"},  dmem_addr,      {alu[31:2], 2'b00});
                check({nm, " be"},    32'(dmem_be),   32'(be_e));
                check({nm, " wdata"}, dmem_wdata,     wd_e);
                check({nm, " wbv0"},  32'(wb_valid),  32'd0);
                dmem_ack   = (i == lat);
                dmem_rdata = (i == lat) ? rdata : $urandom;
                tick();
            end
            dmem_ack = 1'b0;
            check({nm, " wbv"},   32'(wb_valid),       32'd1);
            check({nm, " stall"}, 32'(stall_out),      32'd0);
            check({nm, " req0"},  32'(dmem_req),       32'd0);
            check({nm, " exc"},   32'(misaligned_exc), 32'd0);
            check({nm, " wbrd"},  32'(wb_rd),          32'(rd));
            check({nm, " wbwe"},  32'(wb_reg_write),   32'(mr && rd != 5'd0));
            if (mr) check({nm, " wbdata"}, wb_data, exp_load(rdata, alu, f3));
        end else begin
            check({nm, " wbv"},   32'(wb_valid),       32'd1);
            check({nm, " req0"},  32'(dmem_req),       32'd0);
            check({nm, " stall"}, 32'(stall_out),      32'd0);
            check({nm, " exc"},   32'(misaligned_exc), 32'(mis));
            check({nm, " wbrd"},  32'(wb_rd),          32'(rd));
            check({nm, " wbwe"},  32'(wb_reg_write),   32'(!is_mem && rw && rd != 5'd0));
            if (!is_mem) check({nm, " wbdata"}, wb_data, alu);
        end
    endtask

    // Watchdog: the bench is self-bounded, this only guards against a hang.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        int kind;
        logic mr, mw;
        logic [2:0]  f3;
        logic [31:0] alu;

        reset = 1'b1;
        ex_valid = 1'b0; ex_alu_out = '0; ex_rs2_data = '0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_funct3 = '0; ex_rd = '0; ex_reg_write = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;

        // Reset state; an op offered during reset must not be captured.
        tick();
        ex_valid = 1'b1; ex_alu_out = 32'h55; ex_rd = 5'd3; ex_reg_write = 1'b1;
        tick();
        check("rst stall", 32'(stall_out),      32'd0);
        check("rst req",   32'(dmem_req),       32'd0);
        check("rst we",    32'(dmem_we),        32'd0);
        check("rst addr",  dmem_addr,           32'd0);
        check("rst wdata", dmem_wdata,          32'd0);
        check("rst be",    32'(dmem_be),        32'd0);
        check("rst wbv",   32'(wb_valid),       32'd0);
        check("rst wbd",   wb_data,             32'd0);
        check("rst wbrd",  32'(wb_rd),          32'd0);
        check("rst wbwe",  32'(wb_reg_write),   32'd0);
        check("rst exc",   32'(misaligned_exc), 32'd0);
        reset = 1'b0; ex_valid = 1'b0;
        tick();
        check("rst nocap", 32'(wb_valid), 32'd0);

        // Directed cases.
        run_txn("alu", 32'h42, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 1, 32'h0);
        check("alu data", wb_data, 32'h42);
        run_txn("lb", 32'h1003, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 2, 32'h80FF_FF00);
        check("lb data", wb_data, 32'hFFFF_FF80);
        run_txn("lbu", 32'h1003, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b100, 2, 32'h80FF_FF00);
        check("lbu data", wb_data, 32'h0000_0080);
        run_txn("sh", 32'h2002, 32'h1234_ABCD, 5'd9, 1'b0, 1'b0, 1'b1, 3'b001, 1, 32'h0);
        run_txn("lw mis", 32'h3001, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 1, 32'h0);
        tick();
        check("mis pulse", 32'(misaligned_exc), 32'd0);
        check("wbv pulse", 32'(wb_valid),       32'd0);
        run_txn("alu rd0", 32'h77, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1, 32'h0);
        run_txn("rw conf", 32'h4000, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 3'b010, 1, 32'h0);
        run_txn("bad f3",  32'h4000, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b011, 1, 32'h0);
        run_txn("lh", 32'h5002, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b001, 3, 32'h8001_7FFF);
        check("lh data", wb_data, 32'hFFFF_8001);

        // Reset during ACCESS abandons the load; a later ack is ignored.
        ex_valid = 1'b1; ex_alu_out = 32'h6000; ex_rd = 5'd10; ex_reg_write = 1'b1;
        ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
        tick();
        ex_valid = 1'b0;
        check("ra stall", 32'(stall_out), 32'd1);
        check("ra req",   32'(dmem_req),  32'd1);
        tick();
        reset = 1'b1;
        #1;
        check("ra stall in rst", 32'(stall_out), 32'd0);
        tick();
        reset = 1'b0; dmem_ack = 1'b1;
        check("ra req0",  32'(dmem_req),  32'd0);
        check("ra wbv0",  32'(wb_valid),  32'd0);
        tick();
        dmem_ack = 1'b0;
        check("ra ack idle req", 32'(dmem_req),  32'd0);
        check("ra ack idle wbv", 32'(wb_valid),  32'd0);
        check("ra idle stall",   32'(stall_out), 32'd0);

        // Randomized transactions.
        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 9);
            mr = 1'b0; mw = 1'b0;
            if (kind >= 4 && kind <= 6)      mr = 1'b1;
            else if (kind == 7 || kind == 8) mw = 1'b1;
            else if (kind == 9) begin mr = 1'b1; mw = 1'b1; end
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
            else if (mw)                   f3 = 3'($urandom_range(0, 2));
            else                           f3 = ld_f3[$urandom_range(0, 4)];
            alu = $urandom;
            if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            run_txn("rnd", alu, $urandom, 5'($urandom), 1'($urandom), mr, mw, f3,
                    $urandom_range(1, 3), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                ex_valid = 1'b0;
                dmem_ack = 1'($urandom);
                tick();
                dmem_ack = 1'b0;
                check("gap wbv", 32'(wb_valid),       32'd0);
                check("gap exc", 32'(misaligned_exc), 32'd0);
                check("gap req", 32'(dmem_req),       32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
